// File: rtl/stat_info_reader_pkg.sv
// Shared types and constants for the statistics memory read side.
package stat_pkg;

   localparam int unsigned STAT_RD_LATENCY = 2;
   localparam int unsigned STAT_ADDR_W     = 12;
   localparam int unsigned STAT_DATA_W     = 64;

   // Owner of a read travelling down the return pipeline.
   typedef enum logic {
      SRC_CPU  = 1'b0,
      SRC_DUMP = 1'b1
   } stat_rd_src_t;

   // CPU single-read client.
   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_PEND = 2'd1,
      C_WAIT = 2'd2,
      C_ACK  = 2'd3
   } cpu_state_t;

   // Background sweep client.
   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_RUN   = 2'd1,
      D_DRAIN = 2'd2
   } dump_state_t;

endpackage

// File: rtl/stat_info_reader_dump_fifo.sv
// Small shift-register FIFO for dump beats; entry 0 is the registered head.
module stat_dump_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 76,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             iPush,
   input  logic [WIDTH-1:0] ivPushData,
   input  logic             iPop,
   output logic             oValid,
   output logic [WIDTH-1:0] ovHead,
   output logic [CNT_W-1:0] ovCount
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] wrIdx;
   logic [CNT_W-1:0] nextCount;
   logic             doPop;
   logic             doPush;

   // Write slot accounts for a same-cycle pop shifting everything down.
   always_comb begin
      doPop     = iPop && oValid;
      wrIdx     = count - CNT_W'(doPop);
      doPush    = iPush && (wrIdx < CNT_W'(DEPTH));
      nextCount = count + CNT_W'(doPush) - CNT_W'(doPop);
   end

   // Storage shift, push and occupancy tracking.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
         count  <= '0;
         oValid <= 1'b0;
      end else begin
         if (doPop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
               entries[i] <= entries[i + 1];
            end
         end
         if (doPush) begin
            entries[IDX_W'(wrIdx)] <= ivPushData;
         end
         count  <= nextCount;
         oValid <= (nextCount != '0);
      end
   end

   assign ovHead  = entries[0];
   assign ovCount = count;

endmodule

// File: rtl/stat_info_reader.sv
// Read-side master of the statistics memory: CPU single reads plus a full-sweep dump stream.
module stat_info_reader
   import stat_pkg::*;
#(
   parameter int unsigned STAT_CNT        = 2048,
   parameter int unsigned ADDR_W          = STAT_ADDR_W,
   parameter int unsigned DATA_W          = STAT_DATA_W,
   parameter int unsigned DUMP_FIFO_DEPTH = 2
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              iCpuRdReq,
   input  logic [ADDR_W-1:0] ivCpuRdAddr,
   output logic              oCpuBusy,
   output logic              oCpuRdAck,
   output logic [DATA_W-1:0] ovCpuRdData,
   input  logic              iDumpStart,
   output logic              oDumpBusy,
   output logic              oDumpValid,
   input  logic              iDumpReady,
   output logic [ADDR_W-1:0] ovDumpIndex,
   output logic [DATA_W-1:0] ovDumpData,
   output logic              qStatREn,
   output logic [ADDR_W-1:0] qvStatRAddr,
   input  logic [DATA_W-1:0] qvStatRData
);

   localparam int unsigned CNT_W  = $clog2(DUMP_FIFO_DEPTH + 1);
   localparam int unsigned OCC_W  = CNT_W + 1;
   localparam int unsigned FIFO_W = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STAT_CNT - 1);

   cpu_state_t   cpuState;
   dump_state_t  dumpState;
   logic [ADDR_W-1:0] cpuAddr;
   logic              cpuOor;
   logic [ADDR_W-1:0] dumpPtr;
   stat_rd_src_t      issSrc;

   // Return pipeline: stage i is valid i+1 cycles after qStatREn.
   logic              pipeVld [STAT_RD_LATENCY];
   stat_rd_src_t      pipeSrc [STAT_RD_LATENCY];
   logic [ADDR_W-1:0] pipeIdx [STAT_RD_LATENCY];

   logic              retVld;
   stat_rd_src_t      retSrc;
   logic [ADDR_W-1:0] retIdx;

   logic              cpuFree;
   logic              cpuInRange;
   logic              cpuWant;
   logic              cpuIssue;
   logic              dumpIssue;
   logic              dumpRoom;
   logic [OCC_W-1:0]  dumpInFlight;
   logic              dumpPop;
   logic              fifoPush;
   logic [CNT_W-1:0]  fifoCount;
   logic [FIFO_W-1:0] fifoHead;

   assign retVld = pipeVld[STAT_RD_LATENCY-1];
   assign retSrc = pipeSrc[STAT_RD_LATENCY-1];
   assign retIdx = pipeIdx[STAT_RD_LATENCY-1];

   // Slot arbitration: CPU first, dump only with guaranteed FIFO space.
   always_comb begin
      cpuFree    = (cpuState == C_IDLE) || (cpuState == C_ACK);
      cpuInRange = (ivCpuRdAddr <= LAST_IDX);
      cpuWant    = (cpuFree && iCpuRdReq && cpuInRange) ||
                   ((cpuState == C_PEND) && !cpuOor);
      cpuIssue   = cpuWant && !qStatREn;

      dumpInFlight = OCC_W'(qStatREn && (issSrc == SRC_DUMP));
      for (int unsigned i = 0; i < STAT_RD_LATENCY; i++) begin
         dumpInFlight = dumpInFlight + OCC_W'(pipeVld[i] && (pipeSrc[i] == SRC_DUMP));
      end
      dumpRoom  = (OCC_W'(fifoCount) + dumpInFlight) < OCC_W'(DUMP_FIFO_DEPTH);
      dumpIssue = !cpuWant && !qStatREn && (dumpState == D_RUN) && dumpRoom;

      dumpPop  = oDumpValid && iDumpReady;
      fifoPush = retVld && (retSrc == SRC_DUMP);
   end

   // Memory read port and return tracking.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         qStatREn    <= 1'b0;
         qvStatRAddr <= '0;
         issSrc      <= SRC_CPU;
         for (int unsigned i = 0; i < STAT_RD_LATENCY; i++) begin
            pipeVld[i] <= 1'b0;
            pipeSrc[i] <= SRC_CPU;
            pipeIdx[i] <= '0;
         end
      end else begin
         qStatREn <= cpuIssue || dumpIssue;
         if (cpuIssue) begin
            qvStatRAddr <= cpuFree ? ivCpuRdAddr : cpuAddr;
            issSrc      <= SRC_CPU;
         end else if (dumpIssue) begin
            qvStatRAddr <= dumpPtr;
            issSrc      <= SRC_DUMP;
         end
         pipeVld[0] <= qStatREn;
         pipeSrc[0] <= issSrc;
         pipeIdx[0] <= qvStatRAddr;
         for (int unsigned i = 1; i < STAT_RD_LATENCY; i++) begin
            pipeVld[i] <= pipeVld[i-1];
            pipeSrc[i] <= pipeSrc[i-1];
            pipeIdx[i] <= pipeIdx[i-1];
         end
      end
   end

   // CPU client FSM; C_ACK accepts a new request like C_IDLE since busy is already low.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         cpuState    <= C_IDLE;
         cpuAddr     <= '0;
         cpuOor      <= 1'b0;
         oCpuBusy    <= 1'b0;
         oCpuRdAck   <= 1'b0;
         ovCpuRdData <= '0;
      end else begin
         oCpuRdAck <= 1'b0;
         case (cpuState)
            C_IDLE, C_ACK: begin
               cpuState <= C_IDLE;
               if (iCpuRdReq) begin
                  cpuAddr  <= ivCpuRdAddr;
                  cpuOor   <= !cpuInRange;
                  oCpuBusy <= 1'b1;
                  cpuState <= cpuIssue ? C_WAIT : C_PEND;
               end
            end
            C_PEND: begin
               if (cpuOor) begin
                  ovCpuRdData <= '0;
                  oCpuRdAck   <= 1'b1;
                  oCpuBusy    <= 1'b0;
                  cpuState    <= C_ACK;
               end else if (cpuIssue) begin
                  cpuState <= C_WAIT;
               end
            end
            C_WAIT: begin
               if (retVld && (retSrc == SRC_CPU)) begin
                  ovCpuRdData <= qvStatRData;
                  oCpuRdAck   <= 1'b1;
                  oCpuBusy    <= 1'b0;
                  cpuState    <= C_ACK;
               end
            end
            default: cpuState <= C_IDLE;
         endcase
      end
   end

   // Dump sweep FSM; busy drops right after the final beat is taken.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         dumpState <= D_IDLE;
         dumpPtr   <= '0;
         oDumpBusy <= 1'b0;
      end else begin
         case (dumpState)
            D_IDLE: begin
               if (iDumpStart) begin
                  dumpState <= D_RUN;
                  dumpPtr   <= '0;
                  oDumpBusy <= 1'b1;
               end
            end
            D_RUN: begin
               if (dumpIssue) begin
                  if (dumpPtr == LAST_IDX) begin
                     dumpState <= D_DRAIN;
                  end else begin
                     dumpPtr <= dumpPtr + ADDR_W'(1);
                  end
               end
            end
            D_DRAIN: begin
               if ((dumpInFlight == '0) &&
                   ((fifoCount == '0) || ((fifoCount == CNT_W'(1)) && dumpPop))) begin
                  dumpState <= D_IDLE;
                  oDumpBusy <= 1'b0;
               end
            end
            default: dumpState <= D_IDLE;
         endcase
      end
   end

   stat_dump_fifo #(
      .DEPTH (DUMP_FIFO_DEPTH),
      .WIDTH (FIFO_W),
      .CNT_W (CNT_W)
   ) uDumpFifo (
      .Clock      (Clock),
      .nReset     (nReset),
      .iPush      (fifoPush),
      .ivPushData ({retIdx, qvStatRData}),
      .iPop       (dumpPop),
      .oValid     (oDumpValid),
      .ovHead     (fifoHead),
      .ovCount    (fifoCount)
   );

   assign ovDumpIndex = fifoHead[FIFO_W-1 -: ADDR_W];
   assign ovDumpData  = fifoHead[DATA_W-1:0];

endmodule
